// File: rtl/bfly_pkg.sv
// Shared constants, types and helpers for the radix-2 butterfly datapath.
package bfly_pkg;

    // Default datapath configuration (DW=9, TW=9, OW=10)
    localparam int unsigned DW_DEF = 9;
    localparam int unsigned TW_DEF = 9;
    localparam int unsigned OW_DEF = DW_DEF + 1;

    // Twiddle fraction bits for a Q2.(TW-2) twiddle
    function automatic int unsigned tw_frac(input int unsigned tw);
        return tw - 2;
    endfunction

    // Half an LSB of the product after the twiddle fraction is dropped
    function automatic int unsigned rnd_const(input int unsigned tw);
        return 32'd1 << (tw - 3);
    endfunction

    localparam int unsigned TW_FRAC = tw_frac(TW_DEF);
    localparam int unsigned RND     = rnd_const(TW_DEF);

    // Complex re/im pair at the default output width
    typedef struct packed {
        logic signed [OW_DEF-1:0] re;
        logic signed [OW_DEF-1:0] im;
    } cplx_t;

    // Clamp a signed value into the signed range of 'width' bits
    function automatic logic signed [31:0] sat_narrow(input logic signed [31:0] value,
                                                      input int unsigned      width);
        logic signed [31:0] lim;
        lim = 32'sd1 <<< (width - 32'd1);
        if (value > lim - 32'sd1) begin
            return lim - 32'sd1;
        end else if (value < -lim) begin
            return -lim;
        end
        return value;
    endfunction

    // True when a signed value is representable in 'width' bits
    function automatic logic fits(input logic signed [31:0] value,
                                  input int unsigned      width);
        logic signed [31:0] lim;
        lim = 32'sd1 <<< (width - 32'd1);
        return (value >= -lim) && (value < lim);
    endfunction

endpackage

// File: rtl/bfly2_pipe_cmul.sv
// Pipelined complex multiply p = w*y (or conj(w)*y) with round-half-up, stages S1-S2.
module cmul_pipe
    import bfly_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned TW = TW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          in_valid,
    input  logic [DW-1:0] yr,
    input  logic [DW-1:0] yi,
    input  logic [TW-1:0] wr,
    input  logic [TW-1:0] wi,
    input  logic          inv,
    output logic          p_valid,
    output logic [DW+2:0] pr,
    output logic [DW+2:0] pi
);

    localparam int unsigned PRW  = DW + TW + 1;
    localparam int unsigned PW   = DW + 3;
    localparam int unsigned FRAC = tw_frac(TW);
    localparam logic [TW-1:0] W_MIN = {1'b1, {(TW-1){1'b0}}};
    localparam logic [TW-1:0] W_MAX = {1'b0, {(TW-1){1'b1}}};
    localparam logic signed [PRW-1:0] RND_E = PRW'(rnd_const(TW));

    logic          v1_q, v1_d;
    logic [DW-1:0] yr1_q, yr1_d, yi1_q, yi1_d;
    logic [TW-1:0] wr1_q, wr1_d, wi1_q, wi1_d;
    logic          v2_q, v2_d;
    logic [PW-1:0] pr_q, pr_d, pi_q, pi_d;

    logic [TW-1:0]          wi_eff;
    logic signed [PRW-1:0]  wr_e, wi_e, yr_e, yi_e, acc_r, acc_i;

    // S1 capture with conjugate select, S2 full-width multiply and rounding
    always_comb begin
        v1_d  = v1_q;
        yr1_d = yr1_q;
        yi1_d = yi1_q;
        wr1_d = wr1_q;
        wi1_d = wi1_q;
        v2_d  = v2_q;
        pr_d  = pr_q;
        pi_d  = pi_q;

        // Negating the most negative twiddle saturates instead of wrapping
        if (inv) begin
            wi_eff = (wi == W_MIN) ? W_MAX : TW'(-wi);
        end else begin
            wi_eff = wi;
        end

        wr_e  = PRW'($signed(wr1_q));
        wi_e  = PRW'($signed(wi1_q));
        yr_e  = PRW'($signed(yr1_q));
        yi_e  = PRW'($signed(yi1_q));
        acc_r = wr_e * yr_e - wi_e * yi_e + RND_E;
        acc_i = wr_e * yi_e + wi_e * yr_e + RND_E;

        if (en) begin
            v1_d  = in_valid;
            yr1_d = yr;
            yi1_d = yi;
            wr1_d = wr;
            wi1_d = wi_eff;
            v2_d  = v1_q;
            pr_d  = PW'(acc_r >>> FRAC);
            pi_d  = PW'(acc_i >>> FRAC);
        end
    end

    // Stage registers; reset drops every in-flight beat
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q  <= 1'b0;
            yr1_q <= '0;
            yi1_q <= '0;
            wr1_q <= '0;
            wi1_q <= '0;
            v2_q  <= 1'b0;
            pr_q  <= '0;
            pi_q  <= '0;
        end else begin
            v1_q  <= v1_d;
            yr1_q <= yr1_d;
            yi1_q <= yi1_d;
            wr1_q <= wr1_d;
            wi1_q <= wi1_d;
            v2_q  <= v2_d;
            pr_q  <= pr_d;
            pi_q  <= pi_d;
        end
    end

    assign p_valid = v2_q;
    assign pr      = pr_q;
    assign pi      = pi_q;

endmodule

// File: rtl/bfly2_pipe.sv
// Three-stage radix-2 butterfly: o0 = x + w*y, o1 = x - w*y, with valid/ready and global stall.
// Build option BFLY2_PIPE_SAT_EN: clamp out-of-range results instead of wrapping.
module bfly2_pipe
    import bfly_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned TW = TW_DEF,
    parameter int unsigned OW = DW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] xr,
    input  logic [DW-1:0] xi,
    input  logic [DW-1:0] yr,
    input  logic [DW-1:0] yi,
    input  logic [TW-1:0] wr,
    input  logic [TW-1:0] wi,
    input  logic          inv,
    input  logic          scale,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] o0r,
    output logic [OW-1:0] o0i,
    output logic [OW-1:0] o1r,
    output logic [OW-1:0] o1i,
    output logic          ovf,
    input  logic          ovf_clr
);

    localparam int unsigned SW = DW + 3;

    logic          en_c;
    logic          p_valid;
    logic [SW-1:0] p_r, p_i;

    logic [DW-1:0] x1r_q, x1r_d, x1i_q, x1i_d, x2r_q, x2r_d, x2i_q, x2i_d;
    logic          sc1_q, sc1_d, sc2_q, sc2_d;
    logic          out_valid_q, out_valid_d;
    logic [OW-1:0] o0r_q, o0r_d, o0i_q, o0i_d, o1r_q, o1r_d, o1i_q, o1i_d;
    logic          ovf_q, ovf_d;

    logic signed [SW-1:0] xe_r, xe_i, pe_r, pe_i;
    logic signed [SW-1:0] s0r, s0i, s1r, s1i;
    logic                 ovf_set;

    // Optional rounded halving: (v + 1) >>> 1
    function automatic logic signed [SW-1:0] post_scale(input logic signed [SW-1:0] v,
                                                       input logic                 s);
        return s ? ((v + SW'(1)) >>> 1) : v;
    endfunction

    // Narrow to the output width, clamping or wrapping by build option
    function automatic logic [OW-1:0] narrow(input logic signed [SW-1:0] v);
`ifdef BFLY2_PIPE_SAT_EN
        return OW'(sat_narrow(32'(v), OW));
`else
        return OW'(v);
`endif
    endfunction

    // All stages advance together whenever the output register can move
    assign en_c     = ~out_valid_q | out_ready;
    assign in_ready = en_c;

    cmul_pipe #(
        .DW (DW),
        .TW (TW)
    ) u_cmul (
        .clk      (clk),
        .rst      (rst),
        .en       (en_c),
        .in_valid (in_valid),
        .yr       (yr),
        .yi       (yi),
        .wr       (wr),
        .wi       (wi),
        .inv      (inv),
        .p_valid  (p_valid),
        .pr       (p_r),
        .pi       (p_i)
    );

    // x/scale delay line alongside the multiplier, S3 add/sub, scale, narrow and overflow
    always_comb begin
        x1r_d       = x1r_q;
        x1i_d       = x1i_q;
        x2r_d       = x2r_q;
        x2i_d       = x2i_q;
        sc1_d       = sc1_q;
        sc2_d       = sc2_q;
        out_valid_d = out_valid_q;
        o0r_d       = o0r_q;
        o0i_d       = o0i_q;
        o1r_d       = o1r_q;
        o1i_d       = o1i_q;
        ovf_d       = ovf_q;

        xe_r = SW'($signed(x2r_q));
        xe_i = SW'($signed(x2i_q));
        pe_r = $signed(p_r);
        pe_i = $signed(p_i);
        s0r  = post_scale(xe_r + pe_r, sc2_q);
        s0i  = post_scale(xe_i + pe_i, sc2_q);
        s1r  = post_scale(xe_r - pe_r, sc2_q);
        s1i  = post_scale(xe_i - pe_i, sc2_q);

        ovf_set = en_c & p_valid &
                  (~fits(32'(s0r), OW) | ~fits(32'(s0i), OW) |
                   ~fits(32'(s1r), OW) | ~fits(32'(s1i), OW));

        if (en_c) begin
            x1r_d       = xr;
            x1i_d       = xi;
            sc1_d       = scale;
            x2r_d       = x1r_q;
            x2i_d       = x1i_q;
            sc2_d       = sc1_q;
            out_valid_d = p_valid;
            o0r_d       = narrow(s0r);
            o0i_d       = narrow(s0i);
            o1r_d       = narrow(s1r);
            o1i_d       = narrow(s1i);
        end

        // A new overflow beats a same-cycle clear
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // Pipeline and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            x1r_q       <= '0;
            x1i_q       <= '0;
            x2r_q       <= '0;
            x2i_q       <= '0;
            sc1_q       <= 1'b0;
            sc2_q       <= 1'b0;
            out_valid_q <= 1'b0;
            o0r_q       <= '0;
            o0i_q       <= '0;
            o1r_q       <= '0;
            o1i_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            x1r_q       <= x1r_d;
            x1i_q       <= x1i_d;
            x2r_q       <= x2r_d;
            x2i_q       <= x2i_d;
            sc1_q       <= sc1_d;
            sc2_q       <= sc2_d;
            out_valid_q <= out_valid_d;
            o0r_q       <= o0r_d;
            o0i_q       <= o0i_d;
            o1r_q       <= o1r_d;
            o1i_q       <= o1i_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign o0r       = o0r_q;
    assign o0i       = o0i_q;
    assign o1r       = o1r_q;
    assign o1i       = o1i_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_bfly2_pipe.sv
// Directed bench for bfly2_pipe at DW=9, TW=9, OW=10.
module tb_bfly2_pipe;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_ready, out_valid, out_ready;
    logic              inv, scale, ovf, ovf_clr;
    logic signed [8:0] xr, xi, yr, yi, wr, wi;
    logic signed [9:0] o0r, o0i, o1r, o1i;

    int n_checks = 0;
    int n_errors = 0;
    int done     = 0;

    always #5 clk = ~clk;

    bfly2_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .xr        (xr),
        .xi        (xi),
        .yr        (yr),
        .yi        (yi),
        .wr        (wr),
        .wi        (wi),
        .inv       (inv),
        .scale     (scale),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o0r       (o0r),
        .o0i       (o0i),
        .o1r       (o1r),
        .o1i       (o1i),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One isolated beat with out_ready high; checks latency, results and ovf
    task automatic beat(input string tag, input int ixr, input int ixi, input int iyr,
                        input int iyi, input int iwr, input int iwi, input logic iinv,
                        input logic iscale, input int e0r, input int e0i, input int e1r,
                        input int e1i, input int eovf);
        int lat;
        xr = 9'(ixr); xi = 9'(ixi); yr = 9'(iyr); yi = 9'(iyi);
        wr = 9'(iwr); wi = 9'(iwi); inv = iinv; scale = iscale;
        in_valid = 1'b1;
        @(negedge clk);
        check({tag, ".in_ready"}, 64'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 8);
        check({tag, ".lat"}, lat, 3);
        check({tag, ".o0r"}, o0r, e0r);
        check({tag, ".o0i"}, o0i, e0i);
        check({tag, ".o1r"}, o1r, e1r);
        check({tag, ".o1i"}, o1i, e1i);
        check({tag, ".ovf"}, 64'(ovf), eovf);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [39:0] stream_exp(input int k);
        return {10'(11 * k), 10'(k), 10'(9 * k), 10'(-3 * k)};
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int e3;
        int seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
        inv = 1'b0; scale = 1'b0;
        xr = '0; xi = '0; yr = '0; yi = '0; wr = '0; wi = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst.out_valid", 64'(out_valid), 0);
        check("rst.o0r", o0r, 0);
        check("rst.o1i", o1i, 0);
        check("rst.ovf", 64'(ovf), 0);
        check("rst.in_ready", 64'(in_ready), 1);
        @(posedge clk);
        #1;

        beat("t1",  100, 0, 50, 0, 128, 0,    1'b0, 1'b0, 150,   0,  50,   0, 0);
        beat("t2a", 100, 0, 64, 0, 0,   -128, 1'b0, 1'b0, 100, -64, 100,  64, 0);
        beat("t2b", 100, 0, 64, 0, 0,   -128, 1'b1, 1'b0, 100,  64, 100, -64, 0);
        beat("t4",  3,   0, 0,  0, 128, 0,    1'b0, 1'b1,   2,   0,   2,   0, 0);
        beat("t4n", -3,  0, 0,  0, 128, 0,    1'b0, 1'b1,  -1,   0,  -1,   0, 0);
        // conj of wi=-256 saturates to +255
        beat("twsat", 0, 0, 0, 128, 0, -256,  1'b1, 1'b0, -255,  0, 255,   0, 0);

`ifdef BFLY2_PIPE_SAT_EN
        e3 = 511;
`else
        e3 = -259;
`endif
        beat("t3",  255, 0, 255, 255, 128, -128, 1'b0, 1'b0, e3, 0, -255, 0, 1);
        beat("t1s", 100, 0, 50,  0,   128, 0,    1'b0, 1'b0, 150, 0, 50,  0, 1);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1 ovf_clr = 1'b0;
        @(negedge clk);
        check("ovf.clr", 64'(ovf), 0);
        @(posedge clk);
        #1;
        // Clear held across an overflowing capture: set wins, then clear takes effect
        ovf_clr = 1'b1;
        beat("t3c", 255, 0, 255, 255, 128, -128, 1'b0, 1'b0, e3, 0, -255, 0, 1);
        check("ovf.clr_after_set", 64'(ovf), 0);
        ovf_clr = 1'b0;

        // Streaming with out_ready pattern 1,0,0 repeating
        fork
            begin : drv
                for (int k = 1; k <= 8; k++) begin
                    logic acc;
                    int   guard;
                    xr = 9'(10 * k); xi = 9'(-k); yr = 9'(k); yi = 9'(2 * k);
                    wr = 9'sd128; wi = '0; inv = 1'b0; scale = 1'b0;
                    in_valid = 1'b1;
                    acc = 1'b0;
                    guard = 0;
                    while (!acc && guard < 50) begin
                        @(negedge clk);
                        acc = in_ready;
                        @(posedge clk);
                        #1;
                        guard++;
                    end
                end
                in_valid = 1'b0;
            end
            begin : rdy
                int i;
                i = 0;
                while (done == 0 && i < 400) begin
                    out_ready = (i % 3 == 0);
                    @(posedge clk);
                    #1;
                    i++;
                end
                out_ready = 1'b1;
            end
            begin : mon
                int          idx;
                int          cyc;
                logic        stalled;
                logic [39:0] prev;
                logic [39:0] cur;
                idx = 0; cyc = 0; stalled = 1'b0; prev = '0;
                while (idx < 8 && cyc < 200) begin
                    @(negedge clk);
                    cyc++;
                    cur = {o0r, o0i, o1r, o1i};
                    check("s5.in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
                    if (stalled) begin
                        check("s5.hold_valid", 64'(out_valid), 1);
                        check("s5.hold_data", 64'(cur), 64'(prev));
                    end
                    if (out_valid && out_ready) begin
                        check("s5.data", 64'(cur), 64'(stream_exp(idx + 1)));
                        idx++;
                        stalled = 1'b0;
                    end else if (out_valid) begin
                        stalled = 1'b1;
                        prev = cur;
                    end else begin
                        stalled = 1'b0;
                    end
                end
                check("s5.count", idx, 8);
                done = 1;
            end
        join
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset with two beats in flight
        xr = 9'sd100; xi = '0; yr = 9'sd50; yi = '0; wr = 9'sd128; wi = '0;
        inv = 1'b0; scale = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 yr = 9'sd64;
        @(posedge clk);
        #1 in_valid = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("r6.out_valid", 64'(out_valid), 0);
        check("r6.o0r", o0r, 0);
        check("r6.o1r", o1r, 0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("r6.stale", seen, 0);
        @(posedge clk);
        #1;
        beat("post", 100, 0, 50, 0, 128, 0, 1'b0, 1'b0, 150, 0, 50, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
